prbs31_checker: RTL
===================

// Module: prbs31_checker
// PURPOSE
//   Receive-side companion to the on-chip PRBS31 generator (x^31 + x^28 + 1).
//   Takes a serial bitstream, self-synchronises to it and declares lock.
//   Once locked, flags and counts bit errors, and drops lock on excessive
//   error density. Used in loopback and link bring-up on the TT tile I/O.
// PARAMETERS
//   LOCK_COUNT  64   consecutive matching bits in HUNT required to declare lock
//   ERR_WIN     256  bit window (counted on en) for loss-of-lock evaluation
//   ERR_THRESH  8    errors within one ERR_WIN window that force loss of lock
//   CNT_W       16   width of the saturating error counter
// PORTS
//   clk        in   1      clock
//   rst_n      in   1      reset, asynchronous, active-high
//   en         in   1      din valid this cycle; all state frozen when low
//   din        in   1      received serial PRBS bit
//   clr_cnt    in   1      synchronous clear of err_count and window counters
//   locked     out  1      high while FSM is in LOCKED
//   err_pulse  out  1      one-cycle pulse: previous en bit mismatched while LOCKED
//   err_count  out  CNT_W  saturating count of errors seen while LOCKED
//   state      out  2      FSM state: 0=SEED, 1=HUNT, 2=LOCKED
// BEHAVIOUR
//   Reset:
//     - h[30:0], all counters and err_count = 0; state = SEED.
//     - locked = 0, err_pulse = 0.
//   History and prediction:
//     - h[0] is the newest bit.
//     - pred = h[30] ^ h[27], which matches a generator doing
//       lfsr[0] <= lfsr[27]^lfsr[30] and transmitting lfsr[30].
//     - match = (din == pred).
//   Cycle rule: every state change, counter update and shift occurs only on
//   clk edges with en = 1. Outputs are registered and visible the cycle after
//   the sampling edge.
//   SEED:
//     - shift din into h; count 31 en-bits, then go to HUNT with match_cnt = 0.
//   HUNT:
//     - shift din into h (self-sync).
//     - If h == 0: match_cnt := 0. This is the zero-lock guard; an all-zero
//       stream never locks.
//     - Else on match: match_cnt++; on mismatch: match_cnt := 0.
//     - When match_cnt reaches LOCK_COUNT-1 and the current bit matches:
//       go to LOCKED, clear win_cnt and win_err.
//   LOCKED:
//     - Shift pred, not din, into h, so one flipped bit gives exactly one error.
//     - On mismatch: err_pulse = 1 next cycle; err_count++ saturating at
//       2^CNT_W-1; win_err++.
//     - win_cnt counts en-bits 0..ERR_WIN-1. At wrap, win_cnt and win_err := 0.
//     - If win_err would reach ERR_THRESH: go to HUNT, match_cnt := 0,
//       h keeps its contents, locked falls next cycle.
//     - err_count is held (not cleared) on loss of lock.
//   clr_cnt:
//     - Clears err_count, win_cnt and win_err; does not change state.
//     - clr_cnt has priority over a same-cycle error: count stays 0.
//       err_pulse still fires.
//   err_pulse is never asserted outside LOCKED. en = 0 forces err_pulse = 0.
//   Reset mid-operation: immediate return to reset values, regardless of state.
// TESTING
//   1. PRBS31 from seed 1, en = 1: after 31 bits HUNT, after 31+64 bits
//      locked = 1. err_count = 0 over 10k bits.
//   2. Locked, invert one bit: single err_pulse one cycle later, err_count = 1,
//      no further errors, lock held.
//   3. Locked, invert 8 bits within 256: locked drops after the 8th.
//      Clean stream thereafter relocks after 64 matches. err_count = 8.
//   4. Constant-0 input for 1000 bits: state stays HUNT, locked = 0.
//   5. en toggling 50% with a valid stream: lock at bit 95 by en-count,
//      independent of idle cycles. clr_cnt with coincident error: err_count = 0.
//   6. Assert rst_n while LOCKED: locked = 0, state = 0 and err_count = 0
//      asynchronously.

Source files
------------

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker.
// Synchronises to a serial PRBS31 stream and declares lock. While locked it
// flags and counts bit errors. It drops lock when errors in one window get too
// dense.
//
// Input handshake: en is a plain qualifier, with no back-pressure. A bit on
// din is consumed on every rising clk edge where en = 1. When en = 0 the
// checker holds all state, and err_pulse reads 0 on the following cycle.
module prbs31_checker #(
  parameter int LOCK_COUNT = 64,
  parameter int ERR_WIN    = 256,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int WC_W = $clog2(ERR_WIN);
  localparam int WE_W = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [30:0]       h_q;
  logic [4:0]        seed_cnt_q;
  logic [MC_W-1:0]   match_cnt_q;
  logic [WC_W-1:0]   win_cnt_q;
  logic [WE_W-1:0]   win_err_q;
  logic [CNT_W-1:0]  err_count_q;
  logic              err_pulse_q;
  logic              locked_q;

  logic              pred;
  logic              match;
  logic              h_zero;
  logic              seed_done;
  logic              hunt_lock;
  logic              win_wrap;
  logic              thresh_hit;
  logic              err_hit;
  logic              locked_d;
  logic              cnt_sat;

  // Predicted next bit from the two tap positions of the history.
  // h[0] is the newest bit, so h[30] is the bit 31 positions back.
  assign pred       = h_q[30] ^ h_q[27];
  assign match      = (din == pred);
  assign h_zero     = (h_q == 31'd0);
  assign seed_done  = (seed_cnt_q == 5'd30);
  assign hunt_lock  = !h_zero && match && (match_cnt_q == MC_W'(LOCK_COUNT - 1));
  assign win_wrap   = (win_cnt_q == WC_W'(ERR_WIN - 1));
  assign thresh_hit = !match && (win_err_q == WE_W'(ERR_THRESH - 1));
  assign cnt_sat    = (err_count_q == {CNT_W{1'b1}});

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: transitions happen only on bits qualified by en.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        SEED:    if (seed_done)  state_d = HUNT;
        HUNT:    if (hunt_lock)  state_d = LOCKED;
        LOCKED:  if (thresh_hit) state_d = HUNT;
        default: state_d = SEED;
      endcase
    end
  end

  // Output decode: an error only counts while locked and on a valid bit.
  always_comb begin
    err_hit  = en && (state_q == LOCKED) && !match;
    locked_d = (state_d == LOCKED);
  end

  // History shift register.
  // While locked it is fed from the prediction, so a single corrupted din bit
  // cannot pollute the history and cause follow-on errors.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      h_q <= '0;
    end else if (en) begin
      h_q <= {h_q[29:0], (state_q == LOCKED) ? pred : din};
    end
  end

  // Seed counter: fills the history with 31 received bits before hunting.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      seed_cnt_q <= '0;
    end else if (en && (state_q == SEED)) begin
      seed_cnt_q <= seed_done ? 5'd0 : seed_cnt_q + 5'd1;
    end
  end

  // Consecutive-match counter used while hunting.
  // An all-zero history always resets it, so a dead (all-zero) line never locks.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      match_cnt_q <= '0;
    end else if (en) begin
      case (state_q)
        HUNT: begin
          if (h_zero || !match || hunt_lock) begin
            match_cnt_q <= '0;
          end else begin
            match_cnt_q <= match_cnt_q + 1'b1;
          end
        end
        default: match_cnt_q <= '0;
      endcase
    end
  end

  // Error-density window.
  // It restarts on lock entry, on wrap, and on clr_cnt; clr_cnt takes priority.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else if (en) begin
      if (clr_cnt) begin
        win_cnt_q <= '0;
        win_err_q <= '0;
      end else if (state_q == HUNT && hunt_lock) begin
        win_cnt_q <= '0;
        win_err_q <= '0;
      end else if (state_q == LOCKED) begin
        if (thresh_hit || win_wrap) begin
          win_cnt_q <= '0;
          win_err_q <= '0;
        end else begin
          win_cnt_q <= win_cnt_q + 1'b1;
          if (!match) begin
            win_err_q <= win_err_q + 1'b1;
          end
        end
      end
    end
  end

  // Saturating error counter. It holds its value across loss of lock;
  // only reset or clr_cnt clears it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_count_q <= '0;
    end else if (en) begin
      if (clr_cnt) begin
        err_count_q <= '0;
      end else if (err_hit && !cnt_sat) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  // Registered status outputs. err_pulse updates every cycle, so en = 0 clears it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      err_pulse_q <= err_hit;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule
